sap1_control_sequencer: RTL
===========================

Name: sap1_control_sequencer

Overview:
- Control sequencer for the SAP-1 CPU. It is the initiator side of the bus-control interface that register A, register B, PC, MAR, RAM, IR and the output register respond to.
- A 6-state one-hot ring counter (T1..T6) combines with the 4-bit opcode from the IR to produce the per-cycle control word. That word includes the b_load strobe that loads register B from the bus.
- Halts on HLT until reset.

Parameters:
OP_LDA  4'h0  opcode: load A from memory
OP_ADD  4'h1  opcode: A <= A + mem
OP_SUB  4'h2  opcode: A <= A - mem
OP_OUT  4'hE  opcode: copy A to output register
OP_HLT  4'hF  opcode: halt sequencer

Ports:
clk       input   1  system clock, rising edge
rst       input   1  synchronous active-low reset
opcode    input   4  IR upper nibble; must be stable from T4 through T6
t_state   output  6  one-hot ring state; bit0 = T1 … bit5 = T6
pc_inc    output  1  PC increment
pc_en     output  1  PC drives bus
mar_load  output  1  MAR loads from bus
ram_en    output  1  RAM drives bus
ir_load   output  1  IR loads from bus
ir_en     output  1  IR lower nibble (operand address) drives bus
a_load    output  1  register A loads from bus
a_en      output  1  register A drives bus
b_load    output  1  register B loads from bus
alu_en    output  1  ALU result drives bus
alu_sub   output  1  ALU subtract select (0 = add)
out_load  output  1  output register loads from bus
instr_done output 1  one-cycle pulse in T6 of every completed instruction
halt      output  1  sticky halt flag

Behaviour:
- Reset (rst==0 at posedge):
  - t_state <= 6'b000001, halt <= 0.
  - While rst==0, every control output and instr_done is forced to 0, regardless of state.
  - Reset mid-instruction aborts it. The next cycle after release is T1.
- Ring counter: each posedge with rst==1 and halt==0, t_state rotates left (T6 wraps to T1). A single instruction always takes exactly 6 cycles.
- Control word is a combinational decode of t_state and opcode. Any signal not listed below is 0.
- Fetch, independent of opcode:
  - T1: pc_en, mar_load
  - T2: pc_inc
  - T3: ram_en, ir_load
- LDA:
  - T4: ir_en, mar_load
  - T5: ram_en, a_load
  - T6: none
- ADD:
  - T4: ir_en, mar_load
  - T5: ram_en, b_load
  - T6: alu_en, a_load, alu_sub=0
- SUB: same as ADD, except T6 has alu_sub=1.
- OUT:
  - T4: a_en, out_load
  - T5, T6: none
- Undefined opcode: T4–T6 all zero (NOP). instr_done still pulses.
- instr_done = 1 during T6 when halt==0.
- HLT:
  - In T4 with opcode==OP_HLT, all controls are 0, and halt <= 1 at that cycle's posedge.
  - Afterwards t_state freezes at its current value (T5 bit) and all controls stay 0. instr_done never pulses.
  - Only rst==0 clears halt.
- Bus exclusivity: at most one of pc_en, ram_en, ir_en, a_en, alu_en is high in any cycle.
- opcode changes during T1–T3 have no effect on outputs.

Test Plan:
- Reset: hold rst=0 two cycles with opcode=4'h1, then release → t_state=6'b000001, all controls 0 during reset, T1 shows pc_en=1 and mar_load=1 on the first released cycle.
- ADD sequence: opcode=4'h1, run 6 cycles → exact per-T word; b_load=1 only in T5; alu_en=a_load=1 with alu_sub=0 in T6; instr_done=1 in T6; t_state back to 6'b000001 on cycle 7.
- SUB then LDA back-to-back: opcode=4'h2 for 6 cycles, then 4'h0 → alu_sub=1 only in SUB T6; LDA T5 has ram_en=a_load=1 and b_load=0; 12 cycles total, two instr_done pulses.
- OUT: opcode=4'hE → T4 a_en=out_load=1; T5 and T6 all zero.
- HLT: opcode=4'hF → halt=1 after T4 edge; t_state frozen at 6'b010000 for 20 cycles; all controls and instr_done 0; rst=0 then 1 returns to T1 with halt=0.
- Mid-instruction reset: assert rst=0 during ADD T5 → b_load forced 0 that cycle; next state T1. Bus-exclusivity check across 100 random opcodes.

Source files
------------

// File: rtl/sap1_control_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : sap1_control_sequencer
//  Purpose  : Control sequencer for the SAP-1 CPU. A six-state one-hot ring
//             counter (T1..T6) is decoded together with the IR opcode into
//             the per-cycle bus control word. HLT freezes the ring until reset.
//  Ports    : clk        - system clock, rising edge
//             rst        - synchronous reset, active low
//             opcode     - IR upper nibble, stable from T4 through T6
//             t_state    - one-hot ring state (bit0 = T1 ... bit5 = T6)
//             pc_inc, pc_en, mar_load, ram_en, ir_load, ir_en, a_load, a_en,
//             b_load, alu_en, alu_sub, out_load - control word
//             instr_done - one-cycle pulse in T6 of each completed instruction
//             halt       - sticky halt flag
//  Revision : 1.0 - initial release
// ============================================================================
module sap1_control_sequencer #(
   parameter logic [3:0] OP_LDA = 4'h0,
   parameter logic [3:0] OP_ADD = 4'h1,
   parameter logic [3:0] OP_SUB = 4'h2,
   parameter logic [3:0] OP_OUT = 4'hE,
   parameter logic [3:0] OP_HLT = 4'hF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] opcode,
   output logic [5:0] t_state,
   output logic       pc_inc,
   output logic       pc_en,
   output logic       mar_load,
   output logic       ram_en,
   output logic       ir_load,
   output logic       ir_en,
   output logic       a_load,
   output logic       a_en,
   output logic       b_load,
   output logic       alu_en,
   output logic       alu_sub,
   output logic       out_load,
   output logic       instr_done,
   output logic       halt
);

   typedef enum logic [5:0] {
      T1 = 6'b000001,
      T2 = 6'b000010,
      T3 = 6'b000100,
      T4 = 6'b001000,
      T5 = 6'b010000,
      T6 = 6'b100000
   } t_state_e;

   t_state_e t_state_q, t_state_d;
   logic     halt_q, halt_d;

   // State register
   always_ff @(posedge clk) begin
      if (!rst) begin
         t_state_q <= T1;
         halt_q    <= 1'b0;
      end else begin
         t_state_q <= t_state_d;
         halt_q    <= halt_d;
      end
   end

   // Next state and control-word decode
   always_comb begin
      t_state_d  = t_state_q;
      halt_d     = halt_q;
      pc_inc     = 1'b0;
      pc_en      = 1'b0;
      mar_load   = 1'b0;
      ram_en     = 1'b0;
      ir_load    = 1'b0;
      ir_en      = 1'b0;
      a_load     = 1'b0;
      a_en       = 1'b0;
      b_load     = 1'b0;
      alu_en     = 1'b0;
      alu_sub    = 1'b0;
      out_load   = 1'b0;
      instr_done = 1'b0;

      if (!halt_q) begin
         case (t_state_q)
            T1:      t_state_d = T2;
            T2:      t_state_d = T3;
            T3:      t_state_d = T4;
            T4:      t_state_d = T5;
            T5:      t_state_d = T6;
            T6:      t_state_d = T1;
            // A corrupted (non-one-hot) ring restarts at the fetch cycle.
            default: t_state_d = T1;
         endcase

         // The ring still advances into T5 on the HLT edge and then freezes.
         if (t_state_q == T4 && opcode == OP_HLT) begin
            halt_d = 1'b1;
         end

         // Reset forces the whole control word quiet regardless of state.
         if (rst) begin
            case (t_state_q)
               T1: begin
                  pc_en    = 1'b1;
                  mar_load = 1'b1;
               end
               T2: begin
                  pc_inc = 1'b1;
               end
               T3: begin
                  ram_en  = 1'b1;
                  ir_load = 1'b1;
               end
               T4: begin
                  case (opcode)
                     OP_LDA, OP_ADD, OP_SUB: begin
                        ir_en    = 1'b1;
                        mar_load = 1'b1;
                     end
                     OP_OUT: begin
                        a_en     = 1'b1;
                        out_load = 1'b1;
                     end
                     default: ;
                  endcase
               end
               T5: begin
                  case (opcode)
                     OP_LDA: begin
                        ram_en = 1'b1;
                        a_load = 1'b1;
                     end
                     OP_ADD, OP_SUB: begin
                        ram_en = 1'b1;
                        b_load = 1'b1;
                     end
                     default: ;
                  endcase
               end
               T6: begin
                  instr_done = 1'b1;
                  case (opcode)
                     OP_ADD, OP_SUB: begin
                        alu_en  = 1'b1;
                        a_load  = 1'b1;
                        alu_sub = (opcode == OP_SUB);
                     end
                     default: ;
                  endcase
               end
               default: ;
            endcase
         end
      end
   end

   assign t_state = t_state_q;
   assign halt    = halt_q;

endmodule
`default_nettype wire
